nexys_starship_ssd_decoder: RTL and testbench

//  Receive-side counterpart of the seven-segment scan driver. Watches the multiplexed anode/cathode

---
 rtl/nexys_starship_ssd_decoder.sv | 187 ++++++++++++++++++
 tb/tb_nexys_starship_ssd_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_ssd_decoder.sv
// Seven-segment receive decoder: recovers the lit digit and its hex glyph from
// the multiplexed anode/cathode lines and keeps per-digit result registers.
module nexys_starship_ssd_decoder #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  An,
  input  logic [7:0]  Cath,
  input  logic        clr,
  output logic [31:0] digit_hex,
  output logic [7:0]  digit_valid,
  output logic [7:0]  digit_err,
  output logic [7:0]  digit_dp,
  output logic        update_pulse,
  output logic [2:0]  upd_idx
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CAP_AT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]       BLANK  = 7'b1111111;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [7:0]       s_an, s_cath;
  logic [7:0]       lat_an, lat_cath;
  logic [2:0]       lat_idx;
  logic             relatch, capture;

  logic             s_single;
  logic [2:0]       s_idx;
  logic [7:0]       s_sel;
  logic             s_same;

  logic [3:0]       dec_hex;
  logic             dec_legal;
  logic [3:0]       n_hex;
  logic             n_valid, n_err, n_dp;
  logic             differs;

  // Register the raw pins once; every decision below looks only at this copy.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s_an   <= '0;
      s_cath <= '0;
    end else begin
      s_an   <= An;
      s_cath <= Cath;
    end
  end

  // Single-anode detection and index of the selected digit.
  always_comb begin
    s_sel    = ~s_an;
    s_single = (s_sel != 8'h00) && ((s_sel & (s_sel - 8'h01)) == 8'h00);
    s_idx    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (s_sel[i]) s_idx = 3'(i);
    end
    s_same   = (s_an == lat_an) && (s_cath == lat_cath);
  end

  // Dwell tracking: next state, stability count, relatch and capture strobes.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    relatch   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (s_single) begin
          state_nxt = SETTLE;
          count_nxt = CNT_W'(1);
          relatch   = 1'b1;
        end
      end
      SETTLE, CAPTURED: begin
        if (s_same) begin
          if (state == SETTLE) begin
            if (count != '1) count_nxt = count + 1'b1;
            if (count == CAP_AT) begin
              capture   = 1'b1;
              state_nxt = CAPTURED;
            end
          end
        end else if (s_single) begin
          state_nxt = SETTLE;
          count_nxt = CNT_W'(1);
          relatch   = 1'b1;
        end else begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // FSM state, counter and latched candidate pattern.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      count    <= '0;
      lat_an   <= '0;
      lat_cath <= '0;
      lat_idx  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (relatch) begin
        lat_an   <= s_an;
        lat_cath <= s_cath;
        lat_idx  <= s_idx;
      end
    end
  end

  // Glyph decode of the latched segments {a..g}, active-low.
  always_comb begin
    dec_hex   = '0;
    dec_legal = 1'b1;
    case (lat_cath[7:1])
      7'b0000001: dec_hex = 4'h0;
      7'b1001111: dec_hex = 4'h1;
      7'b0010010: dec_hex = 4'h2;
      7'b0000110: dec_hex = 4'h3;
      7'b1001100: dec_hex = 4'h4;
      7'b0100100: dec_hex = 4'h5;
      7'b0100000: dec_hex = 4'h6;
      7'b0001111: dec_hex = 4'h7;
      7'b0000000: dec_hex = 4'h8;
      7'b0000100: dec_hex = 4'h9;
      7'b0001000: dec_hex = 4'hA;
      7'b1100000: dec_hex = 4'hB;
      7'b0110001: dec_hex = 4'hC;
      7'b1000010: dec_hex = 4'hD;
      7'b0110000: dec_hex = 4'hE;
      7'b0111000: dec_hex = 4'hF;
      default:    dec_legal = 1'b0;
    endcase
    n_hex   = dec_legal ? dec_hex : 4'h0;
    n_valid = dec_legal;
    n_err   = !dec_legal && (lat_cath[7:1] != BLANK);
    n_dp    = ~lat_cath[0];
    differs = (n_hex   != digit_hex[{lat_idx, 2'b00} +: 4]) ||
              (n_valid != digit_valid[lat_idx]) ||
              (n_err   != digit_err[lat_idx]) ||
              (n_dp    != digit_dp[lat_idx]);
  end

  // Per-digit result registers; clr overrides a same-edge capture.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      digit_hex    <= '0;
      digit_valid  <= '0;
      digit_err    <= '0;
      digit_dp     <= '0;
      update_pulse <= 1'b0;
      upd_idx      <= '0;
    end else begin
      update_pulse <= 1'b0;
      if (clr) begin
        digit_hex   <= '0;
        digit_valid <= '0;
        digit_err   <= '0;
        digit_dp    <= '0;
      end else if (capture && differs) begin
        digit_hex[{lat_idx, 2'b00} +: 4] <= n_hex;
        digit_valid[lat_idx]             <= n_valid;
        digit_err[lat_idx]               <= n_err;
        digit_dp[lat_idx]                <= n_dp;
        update_pulse                     <= 1'b1;
        upd_idx                          <= lat_idx;
      end
    end
  end

endmodule

// File: tb/tb_nexys_starship_ssd_decoder.sv
// Scoreboard bench for the seven-segment receive decoder.
module tb_nexys_starship_ssd_decoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  An;
  logic [7:0]  Cath;
  logic        clr;
  logic [31:0] digit_hex;
  logic [7:0]  digit_valid;
  logic [7:0]  digit_err;
  logic [7:0]  digit_dp;
  logic        update_pulse;
  logic [2:0]  upd_idx;

  nexys_starship_ssd_decoder #(
    .STABLE_CYCLES(16),
    .CNT_W(5)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .An(An),
    .Cath(Cath),
    .clr(clr),
    .digit_hex(digit_hex),
    .digit_valid(digit_valid),
    .digit_err(digit_err),
    .digit_dp(digit_dp),
    .update_pulse(update_pulse),
    .upd_idx(upd_idx)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  // Segment codes {a..g}, active-low, for hex 0..F.
  logic [6:0] seg [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  typedef struct {
    logic [2:0] idx;
    logic [3:0] hex;
    logic       v;
    logic       e;
    logic       d;
    int         at;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic [31:0] m_hex = '0;
  logic [7:0]  m_v = '0, m_e = '0, m_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] idx, input logic [3:0] hex, input logic v,
                      input logic e, input logic d, input int at);
    exp_t x;
    x.idx = idx; x.hex = hex; x.v = v; x.e = e; x.d = d; x.at = at;
    q.push_back(x);
    m_hex[{idx, 2'b00} +: 4] = hex;
    m_v[idx] = v;
    m_e[idx] = e;
    m_d[idx] = d;
  endtask

  task automatic clear_model();
    m_hex = '0; m_v = '0; m_e = '0; m_d = '0;
  endtask

  task automatic check_regs(input string name);
    chk({name, "_hex"},   digit_hex,   m_hex);
    chk({name, "_valid"}, {24'h0, digit_valid}, {24'h0, m_v});
    chk({name, "_err"},   {24'h0, digit_err},   {24'h0, m_e});
    chk({name, "_dp"},    {24'h0, digit_dp},    {24'h0, m_d});
  endtask

  // Leaves the caller 1 time unit after the n-th following rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] an, input logic [7:0] cath);
    An   = an;
    Cath = cath;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge Clk);
      n++;
    end
    #1;
    chk({name, "_drained"}, q.size(), 0);
  endtask

  // Monitor: every pulse must match the next expected capture.
  initial begin
    exp_t x;
    forever begin
      @(negedge Clk);
      if (Reset === 1'b1 && update_pulse === 1'b1) begin
        pulses++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual_idx=%0d cycle=%0d required=no_pulse", upd_idx, cyc);
        end else begin
          x = q.pop_front();
          chk("pulse_idx",   {29'h0, upd_idx}, {29'h0, x.idx});
          chk("pulse_cycle", cyc, x.at);
          chk("pulse_hex",   {28'h0, digit_hex[{x.idx, 2'b00} +: 4]}, {28'h0, x.hex});
          chk("pulse_valid", {31'h0, digit_valid[x.idx]}, {31'h0, x.v});
          chk("pulse_err",   {31'h0, digit_err[x.idx]},   {31'h0, x.e});
          chk("pulse_dp",    {31'h0, digit_dp[x.idx]},    {31'h0, x.d});
        end
      end
    end
  end

  initial begin
    int p0;
    int n0;
    Reset = 1'b0;
    clr   = 1'b0;
    An    = 8'hFF;
    Cath  = 8'hFF;
    tick(3);
    chk("reset_hex",   digit_hex, 32'h0);
    chk("reset_valid", {24'h0, digit_valid}, 32'h0);
    chk("reset_err",   {24'h0, digit_err},   32'h0);
    chk("reset_dp",    {24'h0, digit_dp},    32'h0);
    chk("reset_pulse", {31'h0, update_pulse}, 32'h0);
    chk("reset_idx",   {29'h0, upd_idx},     32'h0);
    Reset = 1'b1;
    tick(2);

    // Reset in the middle of a dwell: full fresh dwell needed afterwards.
    p0 = pulses;
    drive(8'hFE, 8'h02);
    tick(11);
    Reset = 1'b0;
    tick(2);
    chk("t1_rst_valid", {24'h0, digit_valid}, 32'h0);
    chk("t1_rst_pulse", {31'h0, update_pulse}, 32'h0);
    Reset = 1'b1;
    push(3'd0, 4'h0, 1'b1, 1'b0, 1'b1, cyc + 17);
    drain("t1", 40);
    tick(5);
    chk("t1_pulses", pulses - p0, 1);
    check_regs("t1");

    // Clear, then plain capture of "0" with Dp lit on digit 0.
    drive(8'hFF, 8'hFF);
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    clear_model();
    check_regs("t2_clr");
    p0 = pulses;
    drive(8'hFE, 8'h02);
    push(3'd0, 4'h0, 1'b1, 1'b0, 1'b1, cyc + 17);
    tick(20);
    drain("t2", 5);
    chk("t2_pulses", pulses - p0, 1);
    check_regs("t2");

    // Short dwell on digit 2: nothing captured.
    p0 = pulses;
    drive(8'hFB, {seg[5], 1'b1});
    tick(10);
    drive(8'hFF, 8'hFF);
    tick(25);
    chk("t4_pulses", pulses - p0, 0);
    check_regs("t4");

    // Illegal glyph on digit 3, then blank.
    p0 = pulses;
    drive(8'hF7, 8'h55);
    push(3'd3, 4'h0, 1'b0, 1'b1, 1'b0, cyc + 17);
    tick(20);
    drain("t5a", 5);
    check_regs("t5a");
    drive(8'hF7, 8'hFF);
    push(3'd3, 4'h0, 1'b0, 1'b0, 1'b0, cyc + 17);
    tick(20);
    drain("t5b", 5);
    chk("t5_pulses", pulses - p0, 2);
    check_regs("t5b");

    // Two anodes low: no capture. Then clr on the capture edge wins.
    p0 = pulses;
    drive(8'hFF, 8'hFF);
    tick(2);
    drive(8'hFC, 8'h02);
    tick(100);
    chk("t6_multi_pulses", pulses - p0, 0);
    check_regs("t6_multi");
    drive(8'hEF, {seg[9], 1'b0});
    n0 = cyc;
    tick(16);
    chk("t6_clr_edge", cyc, n0 + 16);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    clear_model();
    check_regs("t6_clr");
    tick(30);
    chk("t6_pulses", pulses - p0, 0);
    check_regs("t6_hold");

    // Scan loop 0..7 twice: 8 updates in the first pass, none in the second.
    drive(8'hFF, 8'hFF);
    tick(3);
    p0 = pulses;
    for (int l = 0; l < 2; l++) begin
      for (int d = 0; d < 8; d++) begin
        drive(8'(~(8'h01 << d)), {seg[d], 1'b1});
        if (l == 0) push(3'(d), 4'(d), 1'b1, 1'b0, 1'b0, cyc + 17);
        tick(40);
      end
    end
    drive(8'hFF, 8'hFF);
    drain("t3", 5);
    tick(3);
    chk("t3_pulses", pulses - p0, 8);
    chk("t3_hex", digit_hex, 32'h76543210);
    chk("t3_valid", {24'h0, digit_valid}, 32'h000000FF);
    check_regs("t3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
